// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, FSM state type and pattern decoder for the
// segment-bus receive path (and future encoder reuse).
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  // A..G patterns, bit6 = A ... bit0 = G
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } seg7_state_e;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] digit;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [SEG_W-1:0] pat);
    seg7_dec_t d;
    d = '0;
    case (pat)
      SEG_0:     begin d.valid = 1'b1; d.digit = 4'd0; end
      SEG_1:     begin d.valid = 1'b1; d.digit = 4'd1; end
      SEG_2:     begin d.valid = 1'b1; d.digit = 4'd2; end
      SEG_3:     begin d.valid = 1'b1; d.digit = 4'd3; end
      SEG_4:     begin d.valid = 1'b1; d.digit = 4'd4; end
      SEG_5:     begin d.valid = 1'b1; d.digit = 4'd5; end
      SEG_6:     begin d.valid = 1'b1; d.digit = 4'd6; end
      SEG_7:     begin d.valid = 1'b1; d.digit = 4'd7; end
      SEG_8:     begin d.valid = 1'b1; d.digit = 4'd8; end
      SEG_9:     begin d.valid = 1'b1; d.digit = 4'd9; end
      SEG_BLANK: d.blank = 1'b1;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Two-flop synchronizer, sample register and saturating stability counter
// for the asynchronous segment bus.
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] seg_i,
  output logic [7:0] s_o,
  output logic       change_c_o,
  output logic       stable_hit_c_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [7:0]       sync1_q, sync2_q, s_q, s_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      s_q      <= '0;
      s_prev_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= seg_i;
      sync2_q  <= sync1_q;
      s_q      <= sync2_q;
      s_prev_q <= s_q;
      cnt_q    <= cnt_d;
    end
  end

  // Count consecutive identical samples, saturating at STABLE_CYCLES
  always_comb begin
    cnt_d = cnt_q;
    if (s_q != s_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign s_o            = s_q;
  assign change_c_o     = (s_q != s_prev_q);
  assign stable_hit_c_o = (s_q == s_prev_q) && (cnt_q == CNT_W'(STABLE_CYCLES - 1));

endmodule

// File: rtl/seg7_rx_decoder.sv
// Segment-bus receiver: waits for a stable pattern, then locks and decodes it.
// Optional SEG7_RX_SEQ_CHECK_EN adds seq_err for non-incrementing digit locks.
module seg7_rx_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_ABCDEFG_DP,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       dp,
  output logic       blank,
  output logic       pat_err,
  output logic       locked
`ifdef SEG7_RX_SEQ_CHECK_EN
  ,
  output logic       seq_err
`endif
);

  logic [7:0]  s;
  logic        change_c, stable_hit_c;
  seg7_dec_t   dec_c;
  seg7_state_e state_q, state_d;
  logic [3:0]  digit_q, digit_d;
  logic        valid_q, valid_d, dp_q, dp_d, blank_q, blank_d;
  logic        perr_q, perr_d, locked_q, locked_d, have_q, have_d;
`ifdef SEG7_RX_SEQ_CHECK_EN
  logic        seq_q, seq_d;
`endif

  seg7_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk_i          (clk),
    .rst_i          (rst),
    .seg_i          (seg_ABCDEFG_DP),
    .s_o            (s),
    .change_c_o     (change_c),
    .stable_hit_c_o (stable_hit_c)
  );

  assign dec_c = seg7_decode(s[7:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      digit_q  <= '0;
      valid_q  <= 1'b0;
      dp_q     <= 1'b0;
      blank_q  <= 1'b0;
      perr_q   <= 1'b0;
      locked_q <= 1'b0;
      have_q   <= 1'b0;
`ifdef SEG7_RX_SEQ_CHECK_EN
      seq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      perr_q   <= perr_d;
      locked_q <= locked_d;
      have_q   <= have_d;
`ifdef SEG7_RX_SEQ_CHECK_EN
      seq_q    <= seq_d;
`endif
    end
  end

  // Next-state and output update; digit/dp/blank hold unless a lock happens
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    valid_d  = 1'b0;
    dp_d     = dp_q;
    blank_d  = blank_q;
    perr_d   = 1'b0;
    locked_d = locked_q;
    have_d   = have_q;
`ifdef SEG7_RX_SEQ_CHECK_EN
    seq_d    = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = SETTLE;
      SETTLE: begin
        if (stable_hit_c) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
          dp_d     = s[0];
          if (dec_c.valid) begin
            digit_d = dec_c.digit;
            blank_d = 1'b0;
            have_d  = 1'b1;
            if (!have_q || (dec_c.digit != digit_q)) begin
              valid_d = 1'b1;
`ifdef SEG7_RX_SEQ_CHECK_EN
              seq_d   = have_q &&
                        (dec_c.digit != ((digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1));
`endif
            end
          end else if (dec_c.blank) begin
            blank_d = 1'b1;
          end else begin
            perr_d  = 1'b1;
            blank_d = 1'b0;
          end
        end
      end
      LOCKED: begin
        if (change_c) begin
          state_d  = SETTLE;
          locked_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign dp          = dp_q;
  assign blank       = blank_q;
  assign pat_err     = perr_q;
  assign locked      = locked_q;
`ifdef SEG7_RX_SEQ_CHECK_EN
  assign seq_err     = seq_q;
`endif

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Self-checking bench for seg7_rx_decoder: directed table, corner sequences
// and random patterns against a history-window reference model.
module tb_seg7_rx_decoder;

  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg = 8'h00;
  logic [3:0] digit;
  logic       digit_valid, dp, blank, pat_err, locked;
`ifdef SEG7_RX_SEQ_CHECK_EN
  logic       seq_err;
`endif

  seg7_rx_decoder #(.STABLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .seg_ABCDEFG_DP (seg),
    .digit          (digit),
    .digit_valid    (digit_valid),
    .dp             (dp),
    .blank          (blank),
    .pat_err        (pat_err),
    .locked         (locked)
`ifdef SEG7_RX_SEQ_CHECK_EN
    ,
    .seq_err        (seq_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0, perr_cnt = 0, seq_cnt = 0;

  logic [6:0] pats [10];
  logic [7:0] hist [$];
  logic [3:0] m_digit;
  logic       m_valid, m_dp, m_blank, m_perr, m_locked, m_have, m_seq;

  // Synchronized sample seen by the decoder after edge j (zeros from reset)
  function automatic logic [7:0] sval(input int j);
    return (j >= 2) ? hist[j-2] : 8'h00;
  endfunction

  // Lock when the last S+1 synchronized samples agree
  task automatic model_edge(input logic r, input logic [7:0] v);
    int e, d;
    logic same;
    logic [7:0] p;
    m_valid = 1'b0; m_perr = 1'b0; m_seq = 1'b0;
    if (r) begin
      hist.delete();
      m_digit = 4'd0; m_dp = 1'b0; m_blank = 1'b0; m_locked = 1'b0; m_have = 1'b0;
      return;
    end
    e = hist.size();
    hist.push_back(v);
    if (m_locked) begin
      if (sval(e-1) != sval(e-2)) m_locked = 1'b0;
    end else if (e >= S - 1) begin
      same = 1'b1;
      for (int k = e - S - 1; k <= e - 1; k++)
        if (sval(k) != sval(e-1)) same = 1'b0;
      if (same) begin
        p = sval(e-1);
        m_locked = 1'b1;
        m_dp = p[0];
        d = -1;
        for (int i = 0; i < 10; i++) if (pats[i] == p[7:1]) d = i;
        if (d >= 0) begin
          m_blank = 1'b0;
          if (!m_have || d != int'(m_digit)) begin
            m_valid = 1'b1;
            m_seq = m_have && (d != (int'(m_digit) + 1) % 10);
          end
          m_digit = 4'(d);
          m_have = 1'b1;
        end else if (p[7:1] == 7'b0) begin
          m_blank = 1'b1;
        end else begin
          m_perr = 1'b1;
          m_blank = 1'b0;
        end
      end
    end
  endtask

  task automatic check();
    logic [8:0] act, exp;
    act = {digit, digit_valid, dp, blank, pat_err, locked};
    exp = {m_digit, m_valid, m_dp, m_blank, m_perr, m_locked};
`ifdef SEG7_RX_SEQ_CHECK_EN
    if (seq_err) seq_cnt++;
    n_vec++;
    if (seq_err !== m_seq) begin
      n_err++;
      $display("FAIL seq_err t=%0t act=%b exp=%b", $time, seq_err, m_seq);
    end
`endif
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL outputs t=%0t act{digit,valid,dp,blank,perr,locked}=%h,%b%b%b%b%b exp=%h,%b%b%b%b%b",
               $time, act[8:5], act[4], act[3], act[2], act[1], act[0],
               exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
    if (digit_valid) pulse_cnt++;
    if (pat_err) perr_cnt++;
  endtask

  task automatic tick(input logic [7:0] v, input logic r);
    seg = v;
    rst = r;
    @(posedge clk);
    model_edge(r, v);
    @(negedge clk);
    check();
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Hold v with reset released; returns tick index of the first digit_valid
  task automatic latency(input logic [7:0] v, output int found);
    found = -1;
    for (int i = 0; i < 60; i++) begin
      tick(v, 1'b0);
      if (digit_valid && found < 0) found = i;
    end
  endtask

  typedef struct {
    logic [7:0] seg;
    int         hold;
    bit         chk;
    int         digit;
    bit         dp, blank, locked;
    int         pulses, perrs;
  } vec_t;

  vec_t tbl [12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int found, p0, e0;
    logic [7:0] v;
    pats = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    tbl[0]  = '{8'h60, 30, 1, 1, 0, 0, 1, 1, 0};
    tbl[1]  = '{8'h00,  3, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{8'h60, 30, 1, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{8'h81, 30, 1, 1, 1, 0, 1, 0, 1};
    tbl[4]  = '{8'h00, 30, 1, 1, 0, 1, 1, 0, 0};
    tbl[5]  = '{8'h61, 30, 1, 1, 1, 0, 1, 0, 0};
    tbl[6]  = '{8'h60, 30, 1, 1, 0, 0, 1, 0, 0};
    tbl[7]  = '{8'hB6, 30, 1, 5, 0, 0, 1, 1, 0};
    tbl[8]  = '{8'h66, 16, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{8'hB6, 30, 1, 5, 0, 0, 1, 0, 0};
    tbl[10] = '{8'h66, 17, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{8'hB6, 30, 1, 5, 0, 0, 1, 2, 0};

    for (int i = 0; i < 3; i++) tick(8'h00, 1'b1);
    cmp("reset_outputs", int'({digit, digit_valid, dp, blank, pat_err, locked}), 0);

    latency(8'hFC, found);
    cmp("latency_digit0", found, S + 3);
    cmp("digit0_value", int'(digit), 0);
    cmp("digit0_locked", int'(locked), 1);

    for (int t = 0; t < 12; t++) begin
      p0 = pulse_cnt; e0 = perr_cnt;
      for (int c = 0; c < tbl[t].hold; c++) tick(tbl[t].seg, 1'b0);
      if (tbl[t].chk) begin
        cmp($sformatf("tbl%0d_digit", t), int'(digit), tbl[t].digit);
        cmp($sformatf("tbl%0d_dp", t), int'(dp), int'(tbl[t].dp));
        cmp($sformatf("tbl%0d_blank", t), int'(blank), int'(tbl[t].blank));
        cmp($sformatf("tbl%0d_locked", t), int'(locked), int'(tbl[t].locked));
        cmp($sformatf("tbl%0d_pulses", t), pulse_cnt - p0, tbl[t].pulses);
        cmp($sformatf("tbl%0d_perrs", t), perr_cnt - e0, tbl[t].perrs);
      end
    end

    // Dithering between 2 and 3 every 4 cycles never locks
    p0 = pulse_cnt;
    for (int c = 0; c < 200; c++) tick(((c / 4) % 2) ? 8'hF2 : 8'hDA, 1'b0);
    cmp("dither_pulses", pulse_cnt - p0, 0);
    cmp("dither_locked", int'(locked), 0);
    for (int c = 0; c < 30; c++) tick(8'hF2, 1'b0);
    cmp("dither_end_pulses", pulse_cnt - p0, 1);
    cmp("dither_end_digit", int'(digit), 3);

    // Reset while the settle counter sits at 10
    for (int c = 0; c < 14; c++) tick(8'hE0, 1'b0);
    tick(8'hE0, 1'b1);
    cmp("midsettle_reset", int'({digit, digit_valid, dp, blank, pat_err, locked}), 0);
    latency(8'hE0, found);
    cmp("midsettle_latency", found, S + 3);
    cmp("midsettle_digit", int'(digit), 7);

`ifdef SEG7_RX_SEQ_CHECK_EN
    tick(8'h00, 1'b1);
    begin
      logic [7:0] sq [4];
      int exp_seq [4];
      sq = '{8'hFE, 8'hF6, 8'hFC, 8'hDA};
      exp_seq = '{0, 0, 0, 1};
      for (int i = 0; i < 4; i++) begin
        e0 = seq_cnt;
        for (int c = 0; c < 30; c++) tick(sq[i], 1'b0);
        cmp($sformatf("seq_step%0d", i), seq_cnt - e0, exp_seq[i]);
      end
    end
`endif

    // Random patterns, random hold lengths, occasional reset
    for (int n = 0; n < 300; n++) begin
      int r, h;
      r = $urandom_range(0, 12);
      if (r < 10)       v = {pats[r], 1'b0};
      else if (r == 10) v = 8'h00;
      else if (r == 11) v = 8'b1010_1010;
      else              v = 8'b0000_0010;
      v[0] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) tick(v, 1'b1);
      h = $urandom_range(1, 40);
      for (int c = 0; c < h; c++) tick(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_rx_decoder.md
Name: seg7_rx_decoder

Overview:
- Receive-side counterpart of the 7-segment driver: samples an 8-bit segment bus (A..G, DP; active-high segments) and recovers the displayed BCD digit.
- Rejects transients and PWM crossfade dithering between old and new patterns by requiring pattern stability before decoding.
- Used as a loopback checker and scoreboard front-end for the display counter path.

Parameters:
- STABLE_CYCLES, 16, consecutive identical synchronized samples required before lock; legal range 2..65535.
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- seg_ABCDEFG_DP  input  8  segment bus; bit7=A … bit1=G, bit0=DP; asynchronous to clk
- digit  output  4  last successfully decoded digit 0..9
- digit_valid  output  1  one-cycle pulse when a new digit locks
- dp  output  1  DP bit of the last locked pattern
- blank  output  1  level; 1 while the locked pattern has A..G all 0
- pat_err  output  1  one-cycle pulse when a stable pattern is not in the decode table
- locked  output  1  level; 1 while state is LOCKED

Behaviour:
- Input path: 2-flop synchronizer → sample register s; s_prev holds s from the previous cycle.
- Decode table on s[7:1] (bits A..G; DP ignored for decode):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 0000000 = blank
  - Anything else is invalid.
- Stability counter cnt:
  - Clears to 0 when s != s_prev.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM states: IDLE, SETTLE, LOCKED.
  - IDLE: entered on reset; goes to SETTLE on the first cycle after reset.
  - SETTLE → LOCKED: when cnt reaches STABLE_CYCLES-1 and s==s_prev. On that edge the outputs update as follows:
    - Valid digit: digit<=decoded value; digit_valid pulses only if the value differs from the previous locked digit, or if no digit has been locked since reset.
    - Blank pattern: blank<=1; digit holds; no pulse.
    - Invalid pattern: pat_err pulses; digit holds; blank<=0.
    - In all three cases dp<=s[0].
  - LOCKED → SETTLE: on any change s != s_prev; locked<=0 on the same edge; digit, dp and blank hold.
- Latency: a pattern applied at edge 0 and held yields digit_valid high in the cycle after edge STABLE_CYCLES+3.
- Boundary conditions:
  - A change at exactly cnt==STABLE_CYCLES-1 restarts settling; no lock.
  - Dithering between two patterns faster than STABLE_CYCLES never locks.
  - The same digit re-locking after a glitch sets locked but produces no digit_valid pulse.
  - DP-only change: forces SETTLE, then re-lock updates dp; no digit_valid pulse.
- Reset (any time, including mid-settle):
  - Outputs: digit=0, digit_valid=0, dp=0, blank=0, pat_err=0, locked=0.
  - Internal: cnt=0, synchronizer and sample regs=0, "have_digit" flag=0, state=IDLE.

Optional Feature:
- Macro: SEG7_RX_SEQ_CHECK_EN.
- When defined:
  - Adds output seq_err (1 bit).
  - seq_err pulses concurrently with digit_valid when the new digit != (previous digit==9 ? 0 : previous+1).
  - No check on the first lock after reset.
  - Reset value 0.
- When undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package seg7_pkg holds:
  - localparams for the ten A..G patterns and SEG_BLANK
  - FSM state enum (IDLE/SETTLE/LOCKED, 2-bit)
  - function seg7_decode(7-bit) returning {valid, blank, 4-bit digit}
  - Future encoder reuse of the same constants.
- One sub-module, seg7_stable_filter: synchronizer plus stability counter; outputs s and a stable_hit strobe. The FSM and decode stay in the top.

Test Plan:
- Reset, then hold 1111_1100 (digit 0) with STABLE_CYCLES=16 → digit_valid pulse 19 edges later, digit=0, locked=1, dp=0.
- Step 0→1 (0110_0000) held → one digit_valid, digit=1. Then glitch to 0000_0000 for 3 cycles and back to 0110_0000 → locked drops and re-asserts, no digit_valid, blank stays 0.
- Alternate 1101_1010 / 1111_0010 every 4 cycles for 200 cycles → no digit_valid, locked=0; then hold 1111_0010 → digit=3 pulse.
- Hold 1000_0001 (invalid, DP set) → pat_err single pulse, digit unchanged, dp=1. Hold 0000_0000 → blank=1, no pulse.
- Assert rst at cnt=10 of a settle → all outputs 0 next edge; settling restarts, full STABLE_CYCLES+3 latency observed.
- With SEG7_RX_SEQ_CHECK_EN: lock 8, 9, 0, 2 → seq_err only on the lock of 2.
